// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with a shared time base.
//
// One prescaled counter runs in edge-aligned (sawtooth) or center-aligned
// (triangle) mode and is compared against CHANNELS duty values. Period, duty
// and mode are written to shadow registers with upd_i. They move to the
// active registers only at a period boundary, or on the next clock while
// stopped, so the outputs never glitch.
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   en_i          run enable (0 = stopped, time base cleared)
//   hiz_i         tristate all PWM outputs; time base held as when stopped
//   presc_i       counter advances every presc_i+1 clocks
//   period_i      shadow top count
//   duty_i        shadow duties, channel c at [c*WIDTH +: WIDTH]
//   center_i      shadow mode (0 = edge, 1 = center)
//   upd_i         one-clock strobe that captures period/duty/mode into shadow
//   upd_pend_o    shadow captured but not yet transferred
//   ovf_o         one-clock pulse after each period-boundary tick
//   pwm_o         PWM outputs, one clock behind the counter
//
// Optional build macro PWM_DEADTIME_EN adds dt_i (dead time in clocks) and
// the complementary outputs pwm_n_o. Each rising edge of pwm_o and of pwm_n_o
// is delayed by dt_i clocks.
module pwm_multi #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      hiz_i,
  input  logic [PRESC_WIDTH-1:0]    presc_i,
  input  logic [WIDTH-1:0]          period_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic                      center_i,
  input  logic                      upd_i,
`ifdef PWM_DEADTIME_EN
  input  logic [WIDTH-1:0]          dt_i,
  output logic [CHANNELS-1:0]       pwm_n_o,
`endif
  output logic                      upd_pend_o,
  output logic                      ovf_o,
  output logic [CHANNELS-1:0]       pwm_o
);

  localparam logic [WIDTH-1:0]       CNT_ONE   = WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);

  logic                      run, tick, center_eff, bnd, xfer;
  logic [PRESC_WIDTH-1:0]    presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      dir_dn_q, dir_dn_d;
  logic [WIDTH-1:0]          per_sh_q, per_sh_d, per_act_q, per_act_d;
  logic [CHANNELS*WIDTH-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
  logic                      ctr_sh_q, ctr_sh_d, ctr_act_q, ctr_act_d;
  logic                      pend_q, pend_d;
  logic                      ovf_q, ovf_d;
  logic [CHANNELS-1:0]       cmp;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;

  // Time base, boundary detection and shadow/active transfer
  always_comb begin
    run        = en_i & ~hiz_i;
    tick       = (presc_cnt_q == presc_i);
    // A zero period cannot form a triangle, so it runs as edge mode.
    center_eff = ctr_act_q && (per_act_q != '0);
    if (!center_eff) begin
      bnd = run && tick && (cnt_q == per_act_q);
    end else begin
      // Period 1 in center mode never reaches "down at 1", so its top is
      // also its boundary (cycle 0,1).
      bnd = run && tick &&
            ((dir_dn_q && (cnt_q == CNT_ONE)) ||
             (!dir_dn_q && (cnt_q == per_act_q) && (per_act_q == CNT_ONE)));
    end
    xfer = pend_q && (bnd || !run);

    presc_cnt_d = '0;
    cnt_d       = '0;
    dir_dn_d    = 1'b0;
    if (run) begin
      // Also wraps when presc_i was lowered below the running count.
      if (!tick && (presc_cnt_q < presc_i)) presc_cnt_d = presc_cnt_q + PRESC_ONE;
      cnt_d    = cnt_q;
      dir_dn_d = dir_dn_q;
      if (bnd) begin
        cnt_d    = '0;
        dir_dn_d = 1'b0;
      end else if (tick) begin
        if (!center_eff) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (dir_dn_q) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (cnt_q == per_act_q) begin
          cnt_d    = per_act_q - CNT_ONE;
          dir_dn_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end

    per_sh_d  = upd_i ? period_i : per_sh_q;
    duty_sh_d = upd_i ? duty_i   : duty_sh_q;
    ctr_sh_d  = upd_i ? center_i : ctr_sh_q;

    // The transfer takes the shadow as it was before this clock, so an
    // upd_i that coincides with a transfer stays pending.
    per_act_d  = xfer ? per_sh_q  : per_act_q;
    duty_act_d = xfer ? duty_sh_q : duty_act_q;
    ctr_act_d  = xfer ? ctr_sh_q  : ctr_act_q;
    pend_d     = upd_i ? 1'b1 : (xfer ? 1'b0 : pend_q);
    ovf_d      = bnd;

    for (int c = 0; c < CHANNELS; c++) begin
      cmp[c] = run && (cnt_q < duty_act_q[c*WIDTH +: WIDTH]);
    end
  end

`ifdef PWM_DEADTIME_EN
  logic [CHANNELS-1:0] raw_q, raw_d;
  logic [CHANNELS-1:0] neg_q, neg_d;
  logic [WIDTH-1:0]    dtc_q [CHANNELS];
  logic [WIDTH-1:0]    dtc_d [CHANNELS];

  // Dead-time insertion: any change of the compare reloads the per-channel
  // down-counter, and neither output may rise until it has run out.
  always_comb begin
    raw_d = cmp;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!run) begin
        dtc_d[c] = dt_i;
      end else if (raw_d[c] != raw_q[c]) begin
        dtc_d[c] = dt_i;
      end else if (dtc_q[c] != '0) begin
        dtc_d[c] = dtc_q[c] - CNT_ONE;
      end else begin
        dtc_d[c] = '0;
      end
      pwm_d[c] = raw_d[c] && (dtc_d[c] == '0);
      neg_d[c] = run && !raw_d[c] && (dtc_d[c] == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      raw_q <= '0;
      neg_q <= '0;
      for (int c = 0; c < CHANNELS; c++) dtc_q[c] <= '0;
    end else begin
      raw_q <= raw_d;
      neg_q <= neg_d;
      for (int c = 0; c < CHANNELS; c++) dtc_q[c] <= dtc_d[c];
    end
  end

  assign pwm_n_o = hiz_i ? {CHANNELS{1'bz}} : neg_q;
`else
  always_comb begin
    pwm_d = cmp;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      dir_dn_q    <= 1'b0;
      per_sh_q    <= '0;
      duty_sh_q   <= '0;
      ctr_sh_q    <= 1'b0;
      per_act_q   <= '0;
      duty_act_q  <= '0;
      ctr_act_q   <= 1'b0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pwm_q       <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      dir_dn_q    <= dir_dn_d;
      per_sh_q    <= per_sh_d;
      duty_sh_q   <= duty_sh_d;
      ctr_sh_q    <= ctr_sh_d;
      per_act_q   <= per_act_d;
      duty_act_q  <= duty_act_d;
      ctr_act_q   <= ctr_act_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      pwm_q       <= pwm_d;
    end
  end

  assign upd_pend_o = pend_q;
  assign ovf_o      = ovf_q;
  // Tristate is combinational so the pads release in the same cycle.
  assign pwm_o      = hiz_i ? {CHANNELS{1'bz}} : pwm_q;

endmodule
